// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor sequencer.
// Operands are processed LSB-first, one bit per clock, through a single
// full-adder slice built from two half adders and an OR gate.
// Optional build macro SERIAL_ADD_OVF_EN adds the signed-overflow output V.

// Half adder used twice to form the full-adder slice.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
`ifdef SERIAL_ADD_OVF_EN
    logic             v_r;
`endif

    // Full-adder slice: s = a0 ^ b0 ^ c, cout = a0&b0 | c&(a0^b0).
    logic ha0_s_s;
    logic ha0_c_s;
    logic bit_s;
    logic ha1_c_s;
    logic cout_s;

    half_adder u_ha0 (
        .a (a_r[0]),
        .b (b_r[0]),
        .s (ha0_s_s),
        .c (ha0_c_s)
    );

    half_adder u_ha1 (
        .a (ha0_s_s),
        .b (c_r),
        .s (bit_s),
        .c (ha1_c_s)
    );

    assign cout_s = ha0_c_s | ha1_c_s;

    // Sequencer: operand latch, serial shifting, carry tracking and handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            v_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (START) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        a_r     <= A;
                        b_r     <= SUB ? ~B : B;
                        c_r     <= SUB;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r <= {bit_s, sum_r[WIDTH-1:1]};
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    c_r   <= cout_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) begin
                        carry_r <= cout_s;
`ifdef SERIAL_ADD_OVF_EN
                        // c_r still holds the carry into the MSB on this edge.
                        v_r     <= c_r ^ cout_s;
`endif
                        done_r  <= 1'b1;
                        state_r <= FIN;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                FIN: begin
                    // START seen here is deliberately dropped.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign BUSY  = busy_r;
    assign DONE  = done_r;
    assign SUM   = sum_r;
    assign CARRY = carry_r;
`ifdef SERIAL_ADD_OVF_EN
    assign V     = v_r;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8).
// Stimulus pushes arithmetic expectations; a DONE monitor pops and compares.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         SUB = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         CARRY;
`ifdef SERIAL_ADD_OVF_EN
    logic         V;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SUB   (SUB),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .CARRY (CARRY)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         v;
    } exp_t;

    exp_t expq[$];
    int   done_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   issued = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (sub) begin
            e.sum   = W'((ua - ub + 256) % 256);
            e.carry = (ua >= ub);
            sr      = sa - sb;
        end else begin
            e.sum   = W'((ua + ub) % 256);
            e.carry = ((ua + ub) > 255);
            sr      = sa + sb;
        end
        e.v = (sr > 127) || (sr < -128);
        return e;
    endfunction

    // Monitor: each DONE pulse consumes one expectation.
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (DONE === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                chk("unexpected_done", DONE, 0);
            end else begin
                e = expq.pop_front();
                chk("sum", SUM, e.sum);
                chk("carry", CARRY, e.carry);
`ifdef SERIAL_ADD_OVF_EN
                chk("v", V, e.v);
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (BUSY !== 1'b0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("idle_timeout", BUSY, 0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit poke);
        int   n;
        bit   got;
        exp_t e;
        wait_idle();
        START = 1'b1; A = a; B = b; SUB = sub;
        @(posedge CLK);
        e = model(a, b, sub);
        expq.push_back(e);
        issued++;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                chk("busy_rise", BUSY, 1);
                START = 1'b0;
                A = W'($urandom);
                B = W'($urandom);
                SUB = 1'($urandom);
            end
            if (poke && n == 3) begin START = 1'b1; A = 8'hAA; B = 8'h55; end
            if (poke && n == 4) START = 1'b0;
            if (DONE === 1'b1) got = 1;
        end
        chk("done_latency", n, W + 1);
        if (poke) START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("busy_fall", BUSY, 0);
        chk("done_single", DONE, 0);
        chk("sum_hold", SUM, e.sum);
    endtask

    initial begin
        int base;
        exp_t e;
        // Reset state.
        repeat (3) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_carry", CARRY, 0);
        RST = 1'b0;

        // Directed arithmetic cases.
        e = model(8'h3C, 8'h0F, 1'b0);
        chk("model_sanity", e.sum, 8'h4B);
        do_op(8'h3C, 8'h0F, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h05, 8'h07, 1'b1, 1'b0);
        do_op(8'h07, 8'h05, 1'b1, 1'b0);

        // START pulses during RUN and FIN must be ignored.
        base = done_cnt;
        do_op(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (12) @(negedge CLK);
        chk("ignored_start_dones", done_cnt - base, 1);
        chk("ignored_start_idle", BUSY, 0);

        // Reset during RUN discards the operation.
        wait_idle();
        START = 1'b1; A = 8'h33; B = 8'h11; SUB = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_sum", SUM, 0);
        chk("mid_rst_carry", CARRY, 0);
        chk("mid_rst_done", DONE, 0);
        RST = 1'b0;
        base = done_cnt;
        repeat (15) @(negedge CLK);
        chk("mid_rst_no_done", done_cnt - base, 0);
        do_op(8'h01, 8'h01, 1'b0, 1'b0);

        // START held high: back-to-back operations every W+2 cycles.
        wait_idle();
        base = done_cnt;
        START = 1'b1; A = 8'h01; B = 8'h02; SUB = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            if (i % 10 == 0) begin
                expq.push_back(model(8'h01, 8'h02, 1'b0));
                issued++;
            end
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        chk("held_dones", done_cnt - base, 3);
        if (done_cyc.size() >= 3) begin
            chk("held_spacing1", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 10);
            chk("held_spacing2", done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3], 10);
        end

`ifdef SERIAL_ADD_OVF_EN
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b0);
        do_op(8'h05, 8'h03, 1'b0, 1'b0);
`endif

        // Randomized operations.
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        repeat (5) @(negedge CLK);
        chk("done_count", done_cnt, issued);
        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
